apb_uart_arbiter: RTL and testbench

- Two-requester APB master that shares one APB UART slave port (paddr/pselx/penable/pwrite/pwdata/prdata) between two on-chip clients, e.g. a CPU-side config path and a DMA/loopback engine.
- Arbitrates round-robin and sequences the APB IDLE -> SETUP -> ACCESS phases.
- Returns read data, a one-cycle completion pulse and a timeout error to the winning requester.

---
 rtl/apb_uart_arbiter.sv | 167 ++++++++++++++++
 tb/tb_apb_uart_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/apb_uart_arbiter.sv
// Two-requester APB master sharing one APB UART slave port.
// Round-robin arbitration in IDLE, IDLE->SETUP->ACCESS->DONE sequencing,
// registered read data, one-cycle completion pulse and wait-state timeout.
module apb_uart_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              done0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              done1,
  output logic              err1,
  output logic [ADDR_W-1:0] paddr,
  output logic              pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  // Counter holds 0..TIMEOUT-1; at least one bit so TIMEOUT of 0 or 1 still elaborates.
  localparam int CNT_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_INT);
  localparam bit   TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_r;
  logic             last_grant_r;
  logic             grant_r;
  logic [CNT_W-1:0] cnt_r;
  logic             grant_valid_s;
  logic             grant_sel_s;

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    grant_valid_s = req0 | req1;
    grant_sel_s   = 1'b0;
    if (req0 && req1) begin
      grant_sel_s = ~last_grant_r;
    end else if (req1) begin
      grant_sel_s = 1'b1;
    end else begin
      grant_sel_s = 1'b0;
    end
  end

  // APB sequencing FSM; all bus and requester outputs are registered here.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      grant_r      <= 1'b0;
      cnt_r        <= '0;
      paddr        <= '0;
      pwdata       <= '0;
      pwrite       <= 1'b0;
      pselx        <= 1'b0;
      penable      <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses unless re-set below.
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          pselx   <= 1'b0;
          penable <= 1'b0;
          if (grant_valid_s) begin
            grant_r      <= grant_sel_s;
            last_grant_r <= grant_sel_s;
            paddr        <= grant_sel_s ? addr1  : addr0;
            pwdata       <= grant_sel_s ? wdata1 : wdata0;
            pwrite       <= grant_sel_s ? we1    : we0;
            pselx        <= 1'b1;
            state_r      <= ST_SETUP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          pselx   <= 1'b1;
          penable <= 1'b1;
          state_r <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            // Read data is captured only for reads; writes leave rdata alone.
            if (!pwrite) begin
              if (grant_r) begin
                rdata1 <= prdata;
              end else begin
                rdata0 <= prdata;
              end
            end else begin
              rdata0 <= rdata0;
            end
            if (grant_r) begin
              done1 <= 1'b1;
            end else begin
              done0 <= 1'b1;
            end
            pselx   <= 1'b0;
            penable <= 1'b0;
            cnt_r   <= '0;
            state_r <= ST_DONE;
          end else if (TO_EN && (cnt_r == TO_LAST)) begin
            // Slave never answered: finish with the error flag, rdata untouched.
            if (grant_r) begin
              done1 <= 1'b1;
              err1  <= 1'b1;
            end else begin
              done0 <= 1'b1;
              err0  <= 1'b1;
            end
            pselx   <= 1'b0;
            penable <= 1'b0;
            cnt_r   <= '0;
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            state_r <= ST_ACCESS;
          end
        end
        ST_DONE: begin
          pselx   <= 1'b0;
          penable <= 1'b0;
          cnt_r   <= '0;
          state_r <= ST_IDLE;
        end
        default: begin
          pselx   <= 1'b0;
          penable <= 1'b0;
          cnt_r   <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Directed bench for apb_uart_arbiter: write, read, wait states, timeout
// (TIMEOUT=16 and TIMEOUT=0 instances), reset mid-ACCESS and contention.
module tb_apb_uart_arbiter;

  logic       pclk = 1'b0;
  logic       prst;
  logic       req0, we0, req1, we1, pready;
  logic [7:0] addr0, wdata0, addr1, wdata1, prdata;

  logic [7:0] rdata0, rdata1, paddr, pwdata;
  logic       done0, err0, done1, err1, pselx, penable, pwrite;

  logic [7:0] z_rdata0, z_rdata1, z_paddr, z_pwdata;
  logic       z_done0, z_err0, z_done1, z_err1, z_pselx, z_penable, z_pwrite;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 pclk = ~pclk;

  apb_uart_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .pclk(pclk), .prst(prst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .rdata0(rdata0), .done0(done0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .rdata1(rdata1), .done1(done1), .err1(err1),
    .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  apb_uart_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(0)) dut_nto (
    .pclk(pclk), .prst(prst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .rdata0(z_rdata0), .done0(z_done0), .err0(z_err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .rdata1(z_rdata1), .done1(z_done1), .err1(z_err1),
    .paddr(z_paddr), .pselx(z_pselx), .penable(z_penable), .pwrite(z_pwrite),
    .pwdata(z_pwdata), .prdata(prdata), .pready(pready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    prst = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    pready = 1'b1; prdata = 8'h00;
    tick(); tick();
    check("rst_pselx", {31'd0, pselx}, 32'd0);
    check("rst_penable", {31'd0, penable}, 32'd0);
    check("rst_done", {30'd0, done1, done0}, 32'd0);
    check("rst_rdata0", {24'd0, rdata0}, 32'd0);
    check("rst_paddr", {24'd0, paddr}, 32'd0);
    prst = 1'b0;
    tick();
    check("idle_pselx", {31'd0, pselx}, 32'd0);

    // Write from requester 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'hB0; wdata0 = 8'h8B;
    tick();
    check("wr_setup_psel_pen", {30'd0, pselx, penable}, 32'd2);
    check("wr_setup_paddr", {24'd0, paddr}, 32'hB0);
    tick();
    check("wr_access_psel_pen", {30'd0, pselx, penable}, 32'd3);
    check("wr_access_bus", {15'd0, pwrite, pwdata, paddr}, {15'd0, 1'b1, 8'h8B, 8'hB0});
    tick();
    check("wr_done0_err0", {30'd0, done0, err0}, 32'd2);
    check("wr_done1", {31'd0, done1}, 32'd0);
    check("wr_done_psel", {30'd0, pselx, penable}, 32'd0);
    check("wr_rdata0_kept", {24'd0, rdata0}, 32'd0);
    req0 = 1'b0;
    tick();
    check("wr_idle_done0", {31'd0, done0}, 32'd0);
    check("idle_bus_hold", {15'd0, pwrite, pwdata, paddr}, {15'd0, 1'b1, 8'h8B, 8'hB0});

    // Read from requester 1
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'hB4; prdata = 8'hA1;
    tick();
    check("rd_setup_bus", {23'd0, pselx, pwrite, paddr}, {23'd0, 1'b1, 1'b0, 8'hB4});
    tick();
    check("rd_access_pen", {31'd0, penable}, 32'd1);
    tick();
    check("rd_done1_err1", {30'd0, done1, err1}, 32'd2);
    check("rd_rdata1", {24'd0, rdata1}, 32'hA1);
    check("rd_rdata0_kept", {24'd0, rdata0}, 32'd0);
    check("rd_done0", {31'd0, done0}, 32'd0);
    req1 = 1'b0;
    tick();

    // Read with three wait states on requester 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'hC0; pready = 1'b0; prdata = 8'h5C;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("ws_access_pen", {30'd0, pselx, penable}, 32'd3);
      check("ws_no_done", {31'd0, done0}, 32'd0);
      if (i == 3) pready = 1'b1;
      tick();
    end
    check("ws_done0_err0", {30'd0, done0, err0}, 32'd2);
    check("ws_rdata0", {24'd0, rdata0}, 32'h5C);
    req0 = 1'b0;
    tick();

    // Timeout: pready held low, both instances see the same stimulus
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30; pready = 1'b0; prdata = 8'h77;
    tick();
    tick();
    n = 0;
    while (penable && n < 40) begin
      n++;
      tick();
    end
    check("to_access_cycles", n, 32'd16);
    check("to_done0_err0", {30'd0, done0, err0}, 32'd3);
    check("to_rdata0_kept", {24'd0, rdata0}, 32'h5C);
    check("nto_still_access", {29'd0, z_pselx, z_penable, z_done0}, 32'd6);
    req0 = 1'b0;
    tick();
    check("to_idle_done_err", {30'd0, done0, err0}, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("nto_access_long", {29'd0, z_pselx, z_penable, z_done0}, 32'd6);

    // Reset during ACCESS; both requesters then contend
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'h01;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h02;
    tick();
    tick();
    check("rst_mid_pre_pen", {31'd0, penable}, 32'd1);
    prst = 1'b1;
    #1;
    check("rst_mid_psel_pen", {30'd0, pselx, penable}, 32'd0);
    check("rst_mid_done_err", {28'd0, done0, done1, err0, err1}, 32'd0);
    check("rst_mid_nto", {30'd0, z_pselx, z_penable}, 32'd0);
    tick();
    prst = 1'b0; pready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("cont_paddr", {24'd0, paddr}, (t % 2 == 0) ? 32'h10 : 32'h20);
      check("cont_setup_psel", {31'd0, pselx}, 32'd1);
      tick();
      tick();
      check("cont_done", {28'd0, done1, done0, err1, err0},
            (t % 2 == 0) ? 32'b0100 : 32'b1000);
      tick();
      check("cont_idle_done", {30'd0, done1, done0}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
